// File: rtl/axis_fifo_pkg.sv
`default_nettype none
////////////////////////////////////////////////////////////////////////////////
// axis_fifo_pkg : shared sizing helpers and parameter-legality check
// Rev 1.0
////////////////////////////////////////////////////////////////////////////////
package axis_fifo_pkg;

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int entry_w(input int data_width);
      return data_width + (data_width / 8) + 1;
   endfunction

   // Pointers wrap by natural overflow, so DEPTH must be a power of two.
   function automatic bit params_legal(input int depth, input int data_width,
                                       input int ae_thresh, input int af_thresh);
      return (depth >= 4) && ((depth & (depth - 1)) == 0) &&
             (data_width > 0) && ((data_width % 8) == 0) &&
             (ae_thresh < af_thresh) && (af_thresh <= depth);
   endfunction

endpackage
`default_nettype wire

// File: rtl/axis_fifo_ram.sv
`default_nettype none
////////////////////////////////////////////////////////////////////////////////
// axis_fifo_ram : simple dual-port RAM, synchronous write, asynchronous read
// Rev 1.0
////////////////////////////////////////////////////////////////////////////////
module axis_fifo_ram
   import axis_fifo_pkg::*;
#(
   parameter int WIDTH  = 37,
   parameter int DEPTH  = 16,
   localparam int ADDR_W = ptr_w(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [WIDTH-1:0]  i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [WIDTH-1:0]  o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/axis_packet_fifo.sv
`default_nettype none
////////////////////////////////////////////////////////////////////////////////
// axis_packet_fifo : single-clock AXI4-Stream FIFO, cut-through or packet mode
// Rev 1.0
////////////////////////////////////////////////////////////////////////////////
module axis_packet_fifo
   import axis_fifo_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 16,
   parameter int PACKET_MODE = 0,
   parameter int AF_THRESH   = DEPTH - 2,
   parameter int AE_THRESH   = 2,
   localparam int KEEP_WIDTH = DATA_WIDTH / 8,
   localparam int C_CNT_W    = ptr_w(DEPTH) + 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_s_axis_tvalid,
   output logic                  o_s_axis_tready,
   input  logic [DATA_WIDTH-1:0] i_s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] i_s_axis_tkeep,
   input  logic                  i_s_axis_tlast,
   output logic                  o_m_axis_tvalid,
   input  logic                  i_m_axis_tready,
   output logic [DATA_WIDTH-1:0] o_m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] o_m_axis_tkeep,
   output logic                  o_m_axis_tlast,
   output logic [C_CNT_W-1:0]    o_count,
   output logic                  o_almost_full,
   output logic                  o_almost_empty,
   output logic                  o_pkt_overrun
);

   localparam int                 c_PTR_W     = ptr_w(DEPTH);
   localparam logic [C_CNT_W-1:0] c_FULL_CNT  = C_CNT_W'(DEPTH);
   localparam logic [C_CNT_W-1:0] c_AF_CNT    = C_CNT_W'(AF_THRESH);
   localparam logic [C_CNT_W-1:0] c_AE_CNT    = C_CNT_W'(AE_THRESH);
   localparam bit                 c_PARAMS_OK = params_legal(DEPTH, DATA_WIDTH,
                                                             AE_THRESH, AF_THRESH);

   typedef struct packed {
      logic                  tlast;
      logic [KEEP_WIDTH-1:0] tkeep;
      logic [DATA_WIDTH-1:0] tdata;
   } entry_t;

   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [C_CNT_W-1:0] r_count;

   logic   w_full;
   logic   w_s_ready;
   logic   w_m_valid;
   logic   w_overrun;
   logic   w_wr_acc;
   logic   w_rd_acc;
   entry_t w_wr_entry;
   entry_t w_rd_entry;

   // Ready depends only on registered occupancy and reset, never on i_m_axis_tready.
   assign w_full     = (r_count == c_FULL_CNT);
   assign w_s_ready  = !w_full && !i_rst;
   assign w_wr_acc   = i_s_axis_tvalid && w_s_ready;
   assign w_rd_acc   = w_m_valid && i_m_axis_tready;
   assign w_wr_entry = '{tlast: i_s_axis_tlast, tkeep: i_s_axis_tkeep, tdata: i_s_axis_tdata};

   axis_fifo_ram #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH)
   ) u_ram (
      .i_clk   (i_clk),
      .i_we    (w_wr_acc),
      .i_waddr (r_wr_ptr),
      .i_wdata (w_wr_entry),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rd_entry)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + C_CNT_W'(1);
            2'b01:   r_count <= r_count - C_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   generate
      if (PACKET_MODE != 0) begin : g_packet
         logic [C_CNT_W-1:0] r_pkt_cnt;
         logic               r_release;
         logic               w_wr_last;
         logic               w_rd_last;

         assign w_wr_last = w_wr_acc && i_s_axis_tlast;
         assign w_rd_last = w_rd_acc && w_rd_entry.tlast;

         // r_release keeps an oversize packet flowing until its tlast leaves,
         // so the overrun is flagged once rather than every time the FIFO refills.
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               r_pkt_cnt <= '0;
               r_release <= 1'b0;
            end else begin
               case ({w_wr_last, w_rd_last})
                  2'b10:   r_pkt_cnt <= r_pkt_cnt + C_CNT_W'(1);
                  2'b01:   r_pkt_cnt <= r_pkt_cnt - C_CNT_W'(1);
                  default: r_pkt_cnt <= r_pkt_cnt;
               endcase
               if (w_rd_last) begin
                  r_release <= 1'b0;
               end else if (w_overrun) begin
                  r_release <= 1'b1;
               end
            end
         end

         assign w_overrun = w_full && (r_pkt_cnt == '0) && !r_release && !i_rst;
         assign w_m_valid = (r_count != '0) && !i_rst &&
                            ((r_pkt_cnt != '0) || w_full || r_release);
      end else begin : g_cut_through
         assign w_overrun = 1'b0;
         assign w_m_valid = (r_count != '0) && !i_rst;
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         assert (c_PARAMS_OK) else $error("axis_packet_fifo: illegal parameter combination");
      end
   end

   assign o_s_axis_tready = w_s_ready;
   assign o_m_axis_tvalid = w_m_valid;
   assign o_m_axis_tdata  = w_rd_entry.tdata;
   assign o_m_axis_tkeep  = w_rd_entry.tkeep;
   assign o_m_axis_tlast  = w_rd_entry.tlast;
   assign o_count         = r_count;
   assign o_almost_full   = (r_count >= c_AF_CNT);
   assign o_almost_empty  = (r_count <= c_AE_CNT);
   assign o_pkt_overrun   = w_overrun;

endmodule
`default_nettype wire
